// File: rtl/led7seg_scan.sv
// Time-multiplexed scan controller for a shared-cathode 7-segment display.
// Scans one digit per slot with guard blank, 4-bit PWM brightness and per-digit blink.
module led7seg_scan #(
  parameter int NDIG         = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  localparam int DW          = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [8*NDIG-1:0] seg_in,
  input  logic [NDIG-1:0]   blink_mask,
  input  logic [3:0]        brightness,
  output logic [NDIG-1:0]   an,
  output logic [7:0]        cathode,
  output logic [DW-1:0]     digit_idx,
  output logic              frame_tick
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TCW-1:0] TC_MAX  = TCW'(TICK_DIV - 1);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(BLINK_FRAMES - 1);
  localparam logic [DW-1:0]  DIG_MAX = DW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_DRIVE,
    ST_OFF
  } state_t;

  // Handshake: none; all inputs are level-sampled every clk, outputs are registered.
  state_t          state_q, state_d;
  logic [TCW-1:0]  tc_q, tc_d;
  logic [3:0]      phase_q, phase_d;
  logic [DW-1:0]   digit_q, digit_d;
  logic [BCW-1:0]  blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic [7:0]      seg_hold_q, seg_hold_d;
  logic            mask_hold_q, mask_hold_d;
  logic            frame_tick_q, frame_tick_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [7:0]      cathode_q, cathode_d;

  logic            tc_wrap;
  logic            ph_wrap;
  logic            dig_wrap;
  logic [7:0]      seg_sel;
  logic            mask_sel;

  always_comb begin
    seg_sel  = 8'h00;
    mask_sel = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (digit_q == DW'(i)) begin
        seg_sel  = seg_in[8*i +: 8];
        mask_sel = blink_mask[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tc_d         = tc_q;
    phase_d      = phase_q;
    digit_d      = digit_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    seg_hold_d   = seg_hold_q;
    mask_hold_d  = mask_hold_q;
    frame_tick_d = 1'b0;
    an_d         = '1;
    cathode_d    = 8'hFF;

    tc_wrap  = (tc_q == TC_MAX);
    ph_wrap  = tc_wrap && (phase_q == 4'hF);
    dig_wrap = ph_wrap && (digit_q == DIG_MAX);

    tc_d = tc_wrap ? '0 : tc_q + 1'b1;

    // The FSM state advances together with phase, using brightness as seen
    // on the last cycle of the outgoing phase, so a phase never glitches.
    if (tc_wrap) begin
      phase_d = phase_q + 4'd1;
      if (phase_d == 4'd0)
        state_d = ST_BLANK;
      else if (phase_d <= brightness)
        state_d = ST_DRIVE;
      else
        state_d = ST_OFF;
    end

    if (ph_wrap) begin
      digit_d      = dig_wrap ? '0 : digit_q + 1'b1;
      frame_tick_d = dig_wrap;
    end

    if (dig_wrap) begin
      if (blink_cnt_q == BC_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    if (phase_q == 4'd0 && tc_q == '0) begin
      seg_hold_d  = seg_sel;
      mask_hold_d = mask_sel;
    end

    if (state_q == ST_DRIVE && !(mask_hold_q && blink_on_q)) begin
      an_d      = ~(NDIG'(1) << digit_q);
      cathode_d = ~seg_hold_q;
    end

    if (!enable) begin
      state_d      = ST_BLANK;
      tc_d         = '0;
      phase_d      = 4'd0;
      digit_d      = '0;
      blink_cnt_d  = '0;
      blink_on_d   = 1'b0;
      seg_hold_d   = 8'h00;
      mask_hold_d  = 1'b0;
      frame_tick_d = 1'b0;
      an_d         = '1;
      cathode_d    = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      tc_q         <= '0;
      phase_q      <= 4'd0;
      digit_q      <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b0;
      seg_hold_q   <= 8'h00;
      mask_hold_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      cathode_q    <= 8'hFF;
    end else begin
      state_q      <= state_d;
      tc_q         <= tc_d;
      phase_q      <= phase_d;
      digit_q      <= digit_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      seg_hold_q   <= seg_hold_d;
      mask_hold_q  <= mask_hold_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      cathode_q    <= cathode_d;
    end
  end

  assign an         = an_q;
  assign cathode    = cathode_q;
  assign digit_idx  = digit_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Directed bench for led7seg_scan: NDIG=4, TICK_DIV=2, BLINK_FRAMES=2 (32-cycle slots).
module tb_led7seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] seg_in;
  logic [3:0]  blink_mask;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  cathode;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_seg [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};

  led7seg_scan #(.NDIG(4), .TICK_DIV(2), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .seg_in     (seg_in),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .an         (an),
    .cathode    (cathode),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Closed-form expectation: output at cycle c reflects counter step c-1;
  // slot = 32 steps, phase = (step%32)/2, blink_on flips every 256 steps.
  function automatic logic [3:0] m_an(int c, int br, logic [3:0] mask);
    int s, d, ph;
    if (c <= 0) return 4'hF;
    s  = c - 1;
    d  = (s / 32) % 4;
    ph = (s % 32) / 2;
    if (ph >= 1 && ph <= br && !(mask[d] && ((s / 256) % 2 == 1)))
      return ~(4'b0001 << d);
    return 4'hF;
  endfunction

  function automatic logic [7:0] m_cath(int c, int br, logic [3:0] mask);
    logic [3:0] a;
    a = m_an(c, br, mask);
    for (int i = 0; i < 4; i++)
      if (a[i] == 1'b0) return ~exp_seg[i];
    return 8'hFF;
  endfunction

  task automatic run_check(input int n, input int br, input logic [3:0] mask);
    for (int k = 0; k < n; k++) begin
      tick();
      check("an", an, m_an(cyc, br, mask));
      check("cathode", cathode, m_cath(cyc, br, mask));
      check("digit_idx", digit_idx, (cyc / 32) % 4);
      check("frame_tick", frame_tick, (cyc > 0 && cyc % 128 == 0) ? 1 : 0);
      check("an_onehot", ($countones(~an) <= 1) ? 1 : 0, 1);
    end
  endtask

  // driver / scoreboard
  initial begin
    int lows;
    rst        = 1'b1;
    enable     = 1'b1;
    seg_in     = 32'h06_5B_4F_66;
    blink_mask = 4'b0000;
    brightness = 4'd15;

    // Scan at full brightness with digit 1 blinking: frames 0..5.
    blink_mask = 4'b0010;
    do_reset();
    check("rst_an", an, 4'hF);
    check("rst_cathode", cathode, 8'hFF);
    check("rst_digit", digit_idx, 0);
    check("rst_frame_tick", frame_tick, 0);
    run_check(768, 15, 4'b0010);

    // Brightness 4: 8 lit cycles per slot; then brightness 0: always dark.
    blink_mask = 4'b0000;
    brightness = 4'd4;
    do_reset();
    repeat (4) exp_q.push_back(32'd8);
    lows = 0;
    for (int k = 0; k < 128; k++) begin
      tick();
      check("an_br4", an, m_an(cyc, 4, 4'b0000));
      if (an != 4'hF) lows++;
      if (cyc % 32 == 0) begin
        check("lit_count_br4", lows, exp_q.pop_front());
        lows = 0;
      end
    end
    brightness = 4'd0;
    do_reset();
    for (int k = 0; k < 128; k++) begin
      tick();
      check("an_br0", an, 4'hF);
    end

    // seg_in change mid-slot is deferred to the next slot of that digit.
    brightness = 4'd15;
    do_reset();
    for (int k = 0; k < 140; k++) begin
      tick();
      if (cyc == 10) seg_in[7:0] = 8'h3F;
      if (cyc >= 3 && cyc <= 32) check("cath_hold", cathode, 8'h99);
      if (cyc >= 35 && cyc <= 64) check("cath_d1", cathode, 8'hB0);
      if (cyc >= 131) check("cath_new", cathode, 8'hC0);
    end
    seg_in = 32'h06_5B_4F_66;

    // Synchronous reset mid-DRIVE restarts the sequence.
    do_reset();
    run_check(20, 15, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_cathode", cathode, 8'hFF);
    check("mid_rst_digit", digit_idx, 0);
    cyc = 0;
    run_check(40, 15, 4'b0000);

    // enable low during digit 2, then restart at digit 0 without frame_tick.
    do_reset();
    run_check(70, 15, 4'b0000);
    check("pre_dis_digit", digit_idx, 2);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("dis_an", an, 4'hF);
      check("dis_cathode", cathode, 8'hFF);
      check("dis_digit", digit_idx, 0);
      check("dis_frame_tick", frame_tick, 0);
    end
    enable = 1'b1;
    cyc = 0;
    run_check(40, 15, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
